// File: rtl/bl_sched_pkg.sv
// ============================================================================
// bl_sched_pkg : shared state and mode encodings for the backlight scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package bl_sched_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_FILL  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam logic [1:0] MODE_VIDEO = 2'd0;
  localparam logic [1:0] MODE_SOLID = 2'd1;
  localparam logic [1:0] MODE_DOT   = 2'd2;
  localparam logic [1:0] MODE_OFF   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/bl_pattern_gen.sv
// ============================================================================
// bl_pattern_gen : per-zone write data selected by the frame's latched mode
// Rev 1.0
// ============================================================================
`default_nettype none

module bl_pattern_gen
  import bl_sched_pkg::*;
#(
  parameter int N_ZONES = 640,
  parameter int ADDR_W  = 10,
  parameter int DW      = 16
) (
  input  logic [1:0]        I_mode,
  input  logic              I_wd_frame,
  input  logic [ADDR_W-1:0] I_idx,
  input  logic [15:0]       I_frame_cnt,
  input  logic [DW-1:0]     I_tp_level,
  input  logic [DW-1:0]     I_vid_gray,
  output logic [DW-1:0]     O_wtdina
);

  logic [15:0] dot_pos;

  // The lit zone walks with the frame counter, so it advances one zone per frame.
  assign dot_pos = I_frame_cnt % 16'(N_ZONES);

  always_comb begin
    O_wtdina = '0;
    case (I_mode)
      MODE_VIDEO: O_wtdina = I_wd_frame ? '0 : I_vid_gray;
      MODE_SOLID: O_wtdina = I_tp_level;
      MODE_DOT:   O_wtdina = (16'(I_idx) == dot_pos) ? I_tp_level : '0;
      default:    O_wtdina = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bl_frame_sched.sv
// ============================================================================
// bl_frame_sched : frame write sequencer with gap enforcement and video watchdog
// Rev 1.0
// ============================================================================
`default_nettype none

module bl_frame_sched
  import bl_sched_pkg::*;
#(
  parameter int N_ZONES = 640,
  parameter int ADDR_W  = 10,
  parameter int DW      = 16,
  parameter int MIN_GAP = 1024,
  parameter int TIMEOUT = 25_000_000
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic [1:0]        I_mode,
  input  logic [DW-1:0]     I_tp_level,
  input  logic              I_vid_frame_rdy,
  output logic [ADDR_W-1:0] O_vid_addr,
  input  logic [DW-1:0]     I_vid_gray,
  output logic              O_sdbpflag,
  output logic              O_wt_en,
  output logic [ADDR_W-1:0] O_wtaddr,
  output logic [DW-1:0]     O_wtdina,
  output logic              O_busy,
  output logic              O_vid_lost,
  output logic              O_ovf,
  output logic [15:0]       O_frame_cnt
);

  localparam int GAP_W = $clog2(MIN_GAP + 1);
  localparam int WD_W  = $clog2(TIMEOUT);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(N_ZONES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(MIN_GAP - 1);
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d, mode_q, mode_d, mode_prev_q;
  logic [ADDR_W-1:0] idx_q, idx_d, fill_idx, vid_addr_q, vid_addr_d, wtaddr_q, wtaddr_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic [DW-1:0]     wtdina_q, wtdina_d, pat_data;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic wd_frame_q, wd_frame_d, pending_q, pending_d, wd_pend_q, wd_pend_d;
  logic sdbpflag_q, sdbpflag_d, wt_en_q, wt_en_d, busy_q, busy_d;
  logic vid_lost_q, vid_lost_d, ovf_q, ovf_d;
  logic mode_chg, wd_hit, vid_req, trigger, go_start;

  // Index of the zone written in the next cycle; outputs are registered one step ahead.
  assign fill_idx = (state_q == ST_START) ? '0 : idx_q + ADDR_W'(1);

  bl_pattern_gen #(.N_ZONES(N_ZONES), .ADDR_W(ADDR_W), .DW(DW)) u_pat (
    .I_mode      (mode_q),
    .I_wd_frame  (wd_frame_q),
    .I_idx       (fill_idx),
    .I_frame_cnt (frame_cnt_q),
    .I_tp_level  (I_tp_level),
    .I_vid_gray  (I_vid_gray),
    .O_wtdina    (pat_data)
  );

  always_comb begin
    mode_chg = (I_mode != mode_prev_q);
    wd_hit   = (I_mode == MODE_VIDEO) && !mode_chg && !I_vid_frame_rdy && (wd_cnt_q == WD_LAST);
    vid_req  = pending_q | I_vid_frame_rdy;
    trigger  = (I_mode != MODE_VIDEO) | vid_req | wd_pend_q | wd_hit;

    state_d     = state_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    mode_d      = mode_q;
    wd_frame_d  = wd_frame_q;
    frame_cnt_d = frame_cnt_q;
    vid_addr_d  = vid_addr_q;
    sdbpflag_d  = 1'b0;
    wt_en_d     = 1'b0;
    wtaddr_d    = '0;
    wtdina_d    = '0;
    go_start    = 1'b0;

    wd_cnt_d = (I_mode != MODE_VIDEO || mode_chg || I_vid_frame_rdy || wd_hit) ? '0
             : wd_cnt_q + WD_W'(1);
    wd_pend_d  = wd_pend_q | wd_hit;
    vid_lost_d = I_vid_frame_rdy ? 1'b0 : (vid_lost_q | wd_hit);

    // One-deep request: START consumes it, but a pulse landing in START re-arms it.
    pending_d = (state_q == ST_START) ? 1'b0 : pending_q;
    ovf_d     = ovf_q;
    if (I_vid_frame_rdy) begin
      if (pending_q && state_q != ST_START) ovf_d = 1'b1;
      else                                  pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE:  go_start = trigger;
      ST_START: state_d = ST_FILL;
      ST_FILL: begin
        if (idx_q == LAST) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (trigger) go_start = 1'b1;
          else         state_d  = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_start) begin
      state_d     = ST_START;
      sdbpflag_d  = 1'b1;
      vid_addr_d  = '0;
      mode_d      = I_mode;
      wd_frame_d  = (I_mode == MODE_VIDEO) && !vid_req;
      frame_cnt_d = frame_cnt_q + 16'd1;
      wd_pend_d   = 1'b0;
    end

    if (state_d == ST_FILL) begin
      idx_d      = fill_idx;
      wt_en_d    = 1'b1;
      wtaddr_d   = fill_idx;
      wtdina_d   = pat_data;
      vid_addr_d = (fill_idx == LAST) ? LAST : fill_idx + ADDR_W'(1);
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      gap_q       <= '0;
      mode_q      <= MODE_VIDEO;
      mode_prev_q <= MODE_VIDEO;
      wd_frame_q  <= 1'b0;
      pending_q   <= 1'b0;
      wd_pend_q   <= 1'b0;
      wd_cnt_q    <= '0;
      vid_addr_q  <= '0;
      sdbpflag_q  <= 1'b0;
      wt_en_q     <= 1'b0;
      wtaddr_q    <= '0;
      wtdina_q    <= '0;
      busy_q      <= 1'b0;
      vid_lost_q  <= 1'b0;
      ovf_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      mode_q      <= mode_d;
      mode_prev_q <= I_mode;
      wd_frame_q  <= wd_frame_d;
      pending_q   <= pending_d;
      wd_pend_q   <= wd_pend_d;
      wd_cnt_q    <= wd_cnt_d;
      vid_addr_q  <= vid_addr_d;
      sdbpflag_q  <= sdbpflag_d;
      wt_en_q     <= wt_en_d;
      wtaddr_q    <= wtaddr_d;
      wtdina_q    <= wtdina_d;
      busy_q      <= busy_d;
      vid_lost_q  <= vid_lost_d;
      ovf_q       <= ovf_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign O_vid_addr  = vid_addr_q;
  assign O_sdbpflag  = sdbpflag_q;
  assign O_wt_en     = wt_en_q;
  assign O_wtaddr    = wtaddr_q;
  assign O_wtdina    = wtdina_q;
  assign O_busy      = busy_q;
  assign O_vid_lost  = vid_lost_q;
  assign O_ovf       = ovf_q;
  assign O_frame_cnt = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_bl_frame_sched.sv
// ============================================================================
// tb_bl_frame_sched : directed bench for bl_frame_sched (8 zones, gap 4, timeout 100)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bl_frame_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic [15:0] tp;
  logic        rdy;
  logic [2:0]  vid_addr;
  logic [15:0] vid_gray;
  logic        sdb, wt_en, busy, vid_lost, ovf;
  logic [2:0]  wtaddr;
  logic [15:0] wtdina, frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_fc  = 0;

  always #20 clk = ~clk;

  // Zone buffer: zone a holds 0x100 + a.
  assign vid_gray = 16'h0100 + 16'(vid_addr);

  bl_frame_sched #(.N_ZONES(8), .ADDR_W(3), .DW(16), .MIN_GAP(4), .TIMEOUT(100)) dut (
    .I_clk           (clk),
    .I_rst_n         (rst_n),
    .I_mode          (mode),
    .I_tp_level      (tp),
    .I_vid_frame_rdy (rdy),
    .O_vid_addr      (vid_addr),
    .I_vid_gray      (vid_gray),
    .O_sdbpflag      (sdb),
    .O_wt_en         (wt_en),
    .O_wtaddr        (wtaddr),
    .O_wtdina        (wtdina),
    .O_busy          (busy),
    .O_vid_lost      (vid_lost),
    .O_ovf           (ovf),
    .O_frame_cnt     (frame_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flags"}, 32'({sdb, wt_en, busy, vid_lost, ovf}), 32'h0);
    chk({tag, "_addr"},  32'({vid_addr, wtaddr}), 32'h0);
    chk({tag, "_data"},  32'(wtdina), 32'h0);
    chk({tag, "_fcnt"},  32'(frame_cnt), 32'h0);
  endtask

  initial begin
    int n;
    int cnt;
    rst_n = 1'b1;
    mode  = 2'd0;
    tp    = 16'h0;
    rdy   = 1'b0;
    #5 rst_n = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    #5 rst_n = 1'b1;
    tick();
    tick();

    // Video frame from a single ready pulse.
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    exp_fc = 1;
    chk("v1_sdb",  32'(sdb), 32'h1);
    chk("v1_fcnt", 32'(frame_cnt), 32'(exp_fc));
    chk("v1_busy", 32'(busy), 32'h1);
    chk("v1_addr0", 32'(vid_addr), 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("v1_wten", 32'(wt_en), 32'h1);
      chk("v1_waddr", 32'(wtaddr), 32'(i));
      chk("v1_wdata", 32'(wtdina), 32'h100 + 32'(i));
    end
    for (int g = 0; g < 4; g++) begin
      tick();
      chk("v1_gap", 32'({sdb, wt_en, busy}), 32'h1);
    end
    tick();
    chk("v1_idle_busy", 32'(busy), 32'h0);

    // Three pulses during FILL: one queued, two dropped.
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    exp_fc++;
    chk("ovf_sdb", 32'(sdb), 32'h1);
    for (int p = 0; p < 3; p++) begin
      tick();
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
    end
    chk("ovf_flag", 32'(ovf), 32'h1);
    for (int c = 0; c < 6; c++) tick();
    chk("ovf_gap_end", 32'({sdb, busy}), 32'h1);
    tick();
    exp_fc++;
    chk("ovf_extra_sdb", 32'(sdb), 32'h1);
    chk("ovf_extra_fcnt", 32'(frame_cnt), 32'(exp_fc));
    cnt = 0;
    for (int c = 0; c < 13; c++) begin
      tick();
      if (sdb) cnt++;
    end
    chk("ovf_no_third", 32'(cnt), 32'h0);
    chk("ovf_idle_busy", 32'(busy), 32'h0);

    // Walking dot, 10 back-to-back frames at the 13-cycle floor.
    tp   = 16'hABCD;
    mode = 2'd2;
    tick();
    for (int k = 0; k < 10; k++) begin
      exp_fc++;
      chk("dot_sdb", 32'(sdb), 32'h1);
      chk("dot_fcnt", 32'(frame_cnt), 32'(exp_fc));
      for (int i = 0; i < 8; i++) begin
        tick();
        chk("dot_waddr", 32'(wtaddr), 32'(i));
        chk("dot_wdata", 32'(wtdina), (i == exp_fc % 8) ? 32'hABCD : 32'h0);
      end
      if (k == 9) mode = 2'd1;
      for (int g = 0; g < 4; g++) begin
        tick();
        chk("dot_gap", 32'({sdb, wt_en}), 32'h0);
      end
      tick();
    end

    // Solid frame; switch to off mid-FILL, frame still completes solid.
    exp_fc++;
    chk("solid_sdb", 32'(sdb), 32'h1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("solid_wdata", 32'(wtdina), 32'hABCD);
      if (i == 3) mode = 2'd3;
    end
    for (int g = 0; g < 4; g++) tick();
    tick();
    exp_fc++;
    chk("off_sdb", 32'(sdb), 32'h1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("off_wr", 32'({wt_en, wtdina}), 32'h10000);
    end

    // Back to video with no pulses: watchdog frame after the timeout.
    mode = 2'd0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!sdb && n < 200);
    exp_fc++;
    chk("wd_delay", 32'(n), 32'd101);
    chk("wd_lost", 32'(vid_lost), 32'h1);
    chk("wd_fcnt", 32'(frame_cnt), 32'(exp_fc));
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("wd_wr", 32'({wt_en, wtdina}), 32'h10000);
    end
    for (int g = 0; g < 4; g++) tick();
    tick();
    chk("wd_idle", 32'({busy, vid_lost}), 32'h1);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    exp_fc++;
    chk("wd_recover_sdb", 32'(sdb), 32'h1);
    chk("wd_recover_lost", 32'(vid_lost), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("wd_recover_wdata", 32'(wtdina), 32'h100 + 32'(i));
    end

    // Reset at FILL index 4, then no write until the watchdog fires.
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick();
    #5 rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 99; c++) begin
      tick();
      if (wt_en) cnt++;
    end
    chk("rst_no_write", 32'(cnt), 32'h0);
    tick();
    chk("rst_wd_sdb", 32'({sdb, vid_lost}), 32'h3);
    chk("rst_wd_fcnt", 32'(frame_cnt), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
